stream_to_axi_b: RTL and testbench
==================================

Name: stream_to_axi_b

Overview:
- Receiving end of the B-channel snoop stream: consumes stream words tagged with the B stream type and reconstructs AXI4 write-response (B) transactions.
- Drives them out of an AXI slave-side B interface toward a replay or shadow AXI master.
- Buffers responses in a small FIFO.
- Discards foreign-type or malformed stream packets and reports each drop.

Parameters:
- DATA_WIDTH, 128, stream word width.
- ID_WIDTH, 32, AXI ID width.
- USER_WIDTH, 64, AXI BUSER width.
- STREAM_TYPE, 3'b100, type tag identifying B-channel words.
- STREAM_TYPE_WIDTH, 3, width of the type tag.
- FIFO_DEPTH, 4, response buffer entries; power of two, at least 2.

Ports:
- clk  in  1  single clock.
- resetn  in  1  synchronous reset, active low, sampled on the rising edge of clk.
- stream_data  in  DATA_WIDTH  incoming stream word.
- stream_valid  in  1  stream word valid.
- stream_ready  out  1  block accepts the stream word.
- stream_last  in  1  last beat of the stream packet.
- drop  out  1  one-cycle pulse for each accepted beat that is discarded.
- AXIS_bid  out  ID_WIDTH  reconstructed BID.
- AXIS_bresp  out  2  reconstructed BRESP.
- AXIS_buser  out  USER_WIDTH  constant 0 (BUSER is not carried by the stream).
- AXIS_bvalid  out  1  B response valid.
- AXIS_bready  in  1  B response accepted.

Behaviour:
- Word fields:
  - type = stream_data[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH]
  - id = stream_data[DATA_WIDTH-STREAM_TYPE_WIDTH-1 -: ID_WIDTH]
  - resp = stream_data[1:0]
  - padding bits are ignored.
- Beat accepted when stream_valid && stream_ready.
- stream_ready = resetn && !full. It is low when full, even if a pop happens in the same cycle (no full-pass-through).
- FSM state IDLE:
  - Accepted beat with type==STREAM_TYPE and last=1: push {id,resp}, stay IDLE.
  - Type match with last=0 (malformed): drop pulse, go to DISCARD.
  - Type mismatch with last=1: drop pulse, stay IDLE.
  - Type mismatch with last=0: drop pulse, go to DISCARD.
- FSM state DISCARD:
  - Every accepted beat pulses drop and is not pushed.
  - Beat with last=1 returns to IDLE.
- FIFO:
  - First-word-fall-through.
  - AXIS_bvalid = !empty; AXIS_bid and AXIS_bresp come from the head entry.
  - Pop on AXIS_bvalid && AXIS_bready.
  - Latency: push at clock edge N gives AXIS_bvalid high in cycle N+1 if the FIFO was empty.
  - Simultaneous push and pop when not full or empty: count unchanged, pointers both advance modulo FIFO_DEPTH.
  - Push when empty with no pop: bvalid rises next cycle.
  - Pop of the last entry: bvalid low next cycle unless a push occurs in the same cycle.
- Head stability: while AXIS_bvalid is high and AXIS_bready is low, AXIS_bid and AXIS_bresp hold stable (AXI rule).
- Reset values (resetn low, including mid-operation):
  - FSM = IDLE; FIFO pointers and count = 0.
  - AXIS_bvalid = 0, stream_ready = 0, drop = 0.
  - AXIS_bid and AXIS_bresp = 0.
  - Queued entries are lost.
  - Ready rises in the first cycle with resetn high.
- drop is registered-free combinational on the accepted beat; no other output is combinational from stream inputs except stream_ready via full.

Optional Feature:
- Macro STREAM_TO_AXI_B_DROP_CNT_EN.
- Defined: adds output port drop_count (16 bits).
  - Increments on each drop pulse; saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: port and counter absent; drop pulse only.

Decomposition:
- Shared package:
  - Stream type localparams (STREAM_TYPE_B = 3'b100 alongside the other channel tags).
  - STREAM_TYPE_WIDTH.
  - Field-offset functions for type and id extraction.
  - Typedef of the {id,resp} response entry.
- Sub-module: generic sync_fifo (FWFT, parameterized width and depth) instantiated for the response buffer.
- FSM and field decode stay in stream_to_axi_b.

Test Plan (DATA_WIDTH=128, ID_WIDTH=32, STREAM_TYPE=3'b100, FIFO_DEPTH=4):
- Single word {3'b100, 32'hDEADBEEF, 0, 2'b10}, last=1, bready=1 -> next cycle bvalid=1, bid=DEADBEEF, bresp=2'b10, buser=0; popped same cycle; bvalid=0 after.
- bready=0, push 4 valid words (ids 1..4) -> stream_ready=0 after 4th. Then bready=1 for one cycle -> id 1 popped; stream_ready=1 next cycle; order preserved 1,2,3,4.
- Word type 3'b001, last=1 -> drop=1 for one cycle, bvalid stays 0, FSM IDLE.
- 3-beat packet type 3'b010 (last on beat 3), then valid B word id 7 -> three drop pulses, no push; then bid=7 emitted.
- 2 entries queued, bready=0, resetn low for one cycle -> bvalid=0, stream_ready=0 during reset; after reset FIFO empty, stream_ready=1.
- With STREAM_TO_AXI_B_DROP_CNT_EN, force counter path 65540 drops -> drop_count=16'hFFFF, holds; reset -> 0.

Source files
------------

// File: rtl/stream_to_axi_b_pkg.sv
// Shared definitions for the AXI snoop stream endpoints.
// Holds the channel type tags, the tag width, word field-offset helpers, the BRESP type and
// the B-channel receiver FSM state type.
package stream_to_axi_b_pkg;

    // Channel type tags carried in the top bits of every stream word.
    localparam int unsigned STREAM_TYPE_WIDTH = 3;
    localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_AW = 3'b001;
    localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_W  = 3'b010;
    localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_AR = 3'b011;
    localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_B  = 3'b100;
    localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_R  = 3'b101;

    typedef logic [1:0] axi_resp_t;

    typedef enum logic {
        StIdle,
        StDiscard
    } b_state_e;

    // MSB of the type tag: the tag occupies the top bits of the word.
    function automatic int unsigned type_msb(input int unsigned data_width);
        return data_width - 1;
    endfunction

    // MSB of the ID field: directly below the type tag.
    function automatic int unsigned id_msb(input int unsigned data_width,
                                           input int unsigned type_width);
        return data_width - type_width - 1;
    endfunction

endpackage

// File: rtl/stream_to_axi_b_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// Ports: clk_i, rst_ni (synchronous, active low), push_i/wdata_i (write side),
// pop_i/rdata_o (read side, head visible without a pop), full_o, empty_o.
// rdata_o reads as zero while empty so no stale entry leaks out after reset.
module stream_to_axi_b_sync_fifo #(
    parameter int unsigned Width = 34,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    // Depth is a power of two, so pointers wrap naturally.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/stream_to_axi_b.sv
// B-channel snoop stream receiver: turns B-tagged stream words back into AXI4 write responses
// and presents them on a slave-side B interface through a small FWFT buffer. Words of a
// foreign type, or B words that are not single-beat packets, are discarded with a drop pulse.
// Ports: clk, resetn (synchronous, active low); stream_data/valid/ready/last (stream input);
// drop (one pulse per discarded accepted beat); AXIS_bid/bresp/buser/bvalid/bready (B output).
// Optional: define STREAM_TO_AXI_B_DROP_CNT_EN to add drop_count, a 16-bit saturating count of
// drop pulses.
module stream_to_axi_b
    import stream_to_axi_b_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 128,
    parameter int unsigned ID_WIDTH          = 32,
    parameter int unsigned USER_WIDTH        = 64,
    parameter int unsigned STREAM_TYPE_WIDTH = stream_to_axi_b_pkg::STREAM_TYPE_WIDTH,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = STREAM_TYPE_B,
    parameter int unsigned FIFO_DEPTH        = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
`ifdef STREAM_TO_AXI_B_DROP_CNT_EN
    output logic [15:0]           drop_count,
`endif
    input  logic [DATA_WIDTH-1:0] stream_data,
    input  logic                  stream_valid,
    output logic                  stream_ready,
    input  logic                  stream_last,
    output logic                  drop,
    output logic [ID_WIDTH-1:0]   AXIS_bid,
    output logic [1:0]            AXIS_bresp,
    output logic [USER_WIDTH-1:0] AXIS_buser,
    output logic                  AXIS_bvalid,
    input  logic                  AXIS_bready
);

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        axi_resp_t           resp;
    } entry_t;

    localparam int unsigned TypeMsb = type_msb(DATA_WIDTH);
    localparam int unsigned IdMsb   = id_msb(DATA_WIDTH, STREAM_TYPE_WIDTH);
    localparam int unsigned IdLsb   = IdMsb - ID_WIDTH + 1;

    b_state_e                     state_q;
    logic [STREAM_TYPE_WIDTH-1:0] beat_type;
    entry_t                       beat_entry, head_entry;
    logic                         full, empty, accept, push, pop;
    logic                         unused_pad;

    assign beat_type       = stream_data[TypeMsb -: STREAM_TYPE_WIDTH];
    assign beat_entry.id   = stream_data[IdMsb -: ID_WIDTH];
    assign beat_entry.resp = stream_data[1:0];
    assign unused_pad      = ^stream_data[IdLsb-1:2];

    // No full pass-through: a pop in the same cycle does not reopen ready.
    assign stream_ready = resetn && !full;
    assign accept       = stream_valid && stream_ready;
    // Only a single-beat B packet seen from IDLE carries a response.
    assign push = accept && (state_q == StIdle) && (beat_type == STREAM_TYPE) && stream_last;
    assign drop = accept && !push;

    // Gated by resetn so the interface reads idle during a mid-operation reset.
    assign AXIS_bvalid = resetn && !empty;
    assign pop         = AXIS_bvalid && AXIS_bready;
    assign AXIS_bid    = AXIS_bvalid ? head_entry.id : '0;
    assign AXIS_bresp  = AXIS_bvalid ? head_entry.resp : '0;
    assign AXIS_buser  = '0;

    // Any beat without last leaves us discarding until the packet ends.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else if (accept) begin
            state_q <= stream_last ? StIdle : StDiscard;
        end
    end

    stream_to_axi_b_sync_fifo #(
        .Width ($bits(entry_t)),
        .Depth (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .push_i  (push),
        .wdata_i (beat_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef STREAM_TO_AXI_B_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_to_axi_b.sv
// Self-checking bench for stream_to_axi_b: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the response path.
module tb_stream_to_axi_b;

    localparam int DW = 128;
    localparam int IW = 32;
    localparam int UW = 64;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] stream_data = '0;
    logic          stream_valid = 1'b0;
    logic          stream_ready;
    logic          stream_last = 1'b0;
    logic          drop;
    logic [IW-1:0] AXIS_bid;
    logic [1:0]    AXIS_bresp;
    logic [UW-1:0] AXIS_buser;
    logic          AXIS_bvalid;
    logic          AXIS_bready = 1'b0;
`ifdef STREAM_TO_AXI_B_DROP_CNT_EN
    logic [15:0]   drop_count;
`endif

    always #5 clk = ~clk;

    stream_to_axi_b dut (
        .clk          (clk),
        .resetn       (resetn),
`ifdef STREAM_TO_AXI_B_DROP_CNT_EN
        .drop_count   (drop_count),
`endif
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .stream_ready (stream_ready),
        .stream_last  (stream_last),
        .drop         (drop),
        .AXIS_bid     (AXIS_bid),
        .AXIS_bresp   (AXIS_bresp),
        .AXIS_buser   (AXIS_buser),
        .AXIS_bvalid  (AXIS_bvalid),
        .AXIS_bready  (AXIS_bready)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of {id, resp}, a discard flag and a saturating drop tally.
    logic [IW+1:0] model_q [$];
    bit            model_disc = 1'b0;
    int unsigned   model_drops = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkword(input logic [2:0] ty, input logic [IW-1:0] id,
                                             input logic [1:0] rsp);
        logic [DW-1:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[127:125] = ty;
        w[124:93]  = id;
        w[1:0]     = rsp;
        return w;
    endfunction

    // One clock: drive inputs, check outputs at the falling edge, advance the model on the
    // rising edge.
    task automatic cycle(input bit rstn, input bit v, input logic [DW-1:0] d, input bit l,
                         input bit r);
        bit            acc, is_push, has_head;
        logic [2:0]    ty;
        logic [IW+1:0] head;
        resetn       = rstn;
        stream_valid = v;
        stream_data  = d;
        stream_last  = l;
        AXIS_bready  = r;
        ty       = d[127:125];
        acc      = rstn && v && (model_q.size() < FD);
        is_push  = acc && !model_disc && (ty == 3'b100) && l;
        has_head = rstn && (model_q.size() != 0);
        head     = has_head ? model_q[0] : '0;
        @(negedge clk);
        check_eq("stream_ready", stream_ready, rstn && (model_q.size() < FD));
        check_eq("bvalid", AXIS_bvalid, has_head);
        check_eq("bid", AXIS_bid, head[IW+1:2]);
        check_eq("bresp", AXIS_bresp, head[1:0]);
        check_eq("buser", AXIS_buser, '0);
        check_eq("drop", drop, acc && !is_push);
`ifdef STREAM_TO_AXI_B_DROP_CNT_EN
        check_eq("drop_count", drop_count, model_drops);
`endif
        @(posedge clk);
        if (!rstn) begin
            model_q.delete();
            model_disc  = 1'b0;
            model_drops = 0;
        end else begin
            if (has_head && r) void'(model_q.pop_front());
            if (acc) begin
                if (is_push) model_q.push_back({d[124:93], d[1:0]});
                else if (model_drops < 65535) model_drops++;
                model_disc = !l;
            end
        end
        #1;
    endtask

    task automatic idle(input bit r);
        cycle(1'b1, 1'b0, '0, 1'b0, r);
    endtask

    initial begin
        logic [2:0] ty;
        // Reset
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, mkword(3'b100, 32'h5, 2'b00), 1'b1, 1'b0);

        // Single response, popped as soon as it appears
        cycle(1'b1, 1'b1, mkword(3'b100, 32'hDEADBEEF, 2'b10), 1'b1, 1'b1);
        check_eq("t1_bvalid", AXIS_bvalid, 1'b1);
        check_eq("t1_bid", AXIS_bid, 32'hDEADBEEF);
        check_eq("t1_bresp", AXIS_bresp, 2'b10);
        idle(1'b1);
        check_eq("t1_bvalid_after", AXIS_bvalid, 1'b0);

        // Fill to full with bready low, then drain in order
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, mkword(3'b100, i, 2'(i)), 1'b1, 1'b0);
        check_eq("t2_full_ready", stream_ready, 1'b0);
        idle(1'b1);
        check_eq("t2_ready_after_pop", stream_ready, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            check_eq("t2_order", AXIS_bid, i);
            idle(1'b1);
        end
        check_eq("t2_drained", AXIS_bvalid, 1'b0);

        // Foreign single-beat word
        cycle(1'b1, 1'b1, mkword(3'b001, 32'h11, 2'b01), 1'b1, 1'b1);
        check_eq("t3_no_push", AXIS_bvalid, 1'b0);

        // Foreign 3-beat packet followed by a good B word
        cycle(1'b1, 1'b1, mkword(3'b010, 32'h21, 2'b00), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, mkword(3'b100, 32'h22, 2'b00), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, mkword(3'b010, 32'h23, 2'b00), 1'b1, 1'b0);
        check_eq("t4_no_push", AXIS_bvalid, 1'b0);
        cycle(1'b1, 1'b1, mkword(3'b100, 32'h7, 2'b11), 1'b1, 1'b0);
        check_eq("t4_bid", AXIS_bid, 32'h7);
        idle(1'b1);

        // Mid-operation reset with entries queued
        cycle(1'b1, 1'b1, mkword(3'b100, 32'hA1, 2'b01), 1'b1, 1'b0);
        cycle(1'b1, 1'b1, mkword(3'b100, 32'hA2, 2'b10), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        idle(1'b0);
        check_eq("t5_empty_after_reset", AXIS_bvalid, 1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            ty = ($urandom_range(0, 9) < 6) ? 3'b100 : 3'($urandom_range(0, 7));
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7),
                  mkword(ty, $urandom, 2'($urandom)), ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) < 5));
        end

`ifdef STREAM_TO_AXI_B_DROP_CNT_EN
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) cycle(1'b1, 1'b1, mkword(3'b001, i, 2'b00), 1'b1, 1'b1);
        check_eq("cnt_saturated", drop_count, 16'hFFFF);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_eq("cnt_reset", drop_count, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
